// File: rtl/handshake_constant_checker_if.sv
// Valid/ready bundle for the constant checker: data token in, dataless control token out.
interface handshake_constant_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        output ins,
        output ins_valid,
        output outs_ready,
        input  ins_ready,
        input  outs_valid
    );

    modport slave (
        input  ins,
        input  ins_valid,
        input  outs_ready,
        output ins_ready,
        output outs_valid
    );
endinterface

// File: rtl/handshake_constant_checker.sv
// Checks accepted data tokens against a constant and regenerates them as control tokens.
// Optional feature macro: HANDSHAKE_CONSTANT_CHECKER_CAPTURE_EN (captures first mismatching value).
module handshake_constant_checker #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [31:0] EXPECTED    = 32'h2B868BA3,
    parameter int          TOKEN_DEPTH = 2,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    handshake_constant_checker_if.slave  hs,
    output logic [CNT_WIDTH-1:0]         match_count,
    output logic [CNT_WIDTH-1:0]         mismatch_count,
    output logic                         error,
    output logic [DATA_WIDTH-1:0]        first_bad
);

    localparam logic [3:0]            DEPTH   = 4'(TOKEN_DEPTH);
    localparam logic [DATA_WIDTH-1:0] EXP_VAL = DATA_WIDTH'(EXPECTED);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        if (value == {CNT_WIDTH{1'b1}}) begin
            return value;
        end else begin
            return value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [3:0]           occ_r;
    logic [3:0]           occ_next_s;
    logic                 ins_ready_r;
    logic                 outs_valid_r;
    logic                 accept_s;
    logic                 pop_s;
    logic                 is_match_s;
    logic [CNT_WIDTH-1:0] match_r;
    logic [CNT_WIDTH-1:0] mismatch_r;
    logic                 error_r;

    // Handshake qualification and next buffer occupancy.
    always_comb begin
        accept_s   = hs.ins_valid & ins_ready_r;
        pop_s      = outs_valid_r & hs.outs_ready;
        is_match_s = (hs.ins == EXP_VAL);
        occ_next_s = occ_r;
        if (accept_s && !pop_s) begin
            occ_next_s = occ_r + 4'd1;
        end else if (pop_s && !accept_s) begin
            occ_next_s = occ_r - 4'd1;
        end else begin
            occ_next_s = occ_r;
        end
    end

    // Occupancy and the handshake flags derived from the occupancy being loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r        <= 4'd0;
            ins_ready_r  <= 1'b1;
            outs_valid_r <= 1'b0;
        end else begin
            occ_r        <= occ_next_s;
            ins_ready_r  <= (occ_next_s != DEPTH);
            outs_valid_r <= (occ_next_s != 4'd0);
        end
    end

    // Match/mismatch statistics and sticky error, updated only on an accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_r    <= {CNT_WIDTH{1'b0}};
            mismatch_r <= {CNT_WIDTH{1'b0}};
            error_r    <= 1'b0;
        end else if (accept_s) begin
            if (is_match_s) begin
                match_r <= sat_inc(match_r);
            end else begin
                mismatch_r <= sat_inc(mismatch_r);
                error_r    <= 1'b1;
            end
        end else begin
            match_r    <= match_r;
            mismatch_r <= mismatch_r;
            error_r    <= error_r;
        end
    end

`ifdef HANDSHAKE_CONSTANT_CHECKER_CAPTURE_EN
    logic [DATA_WIDTH-1:0] first_bad_r;

    // Capture only the first mismatch; error_r still low marks it as the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_bad_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s && !is_match_s && !error_r) begin
            first_bad_r <= hs.ins;
        end else begin
            first_bad_r <= first_bad_r;
        end
    end

    assign first_bad = first_bad_r;
`else
    assign first_bad = {DATA_WIDTH{1'b0}};
`endif

    assign hs.ins_ready    = ins_ready_r;
    assign hs.outs_valid   = outs_valid_r;
    assign match_count     = match_r;
    assign mismatch_count  = mismatch_r;
    assign error           = error_r;

endmodule

// File: tb/tb_handshake_constant_checker.sv
// Randomized bench for handshake_constant_checker: two instances (16-bit and 4-bit counters)
// driven identically and compared each cycle against a token-counting reference model.
module tb_handshake_constant_checker;

    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] EXP   = 32'h2B868BA3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins_d = 32'd0;
    logic        valid_d = 1'b0;
    logic        ordy_d = 1'b0;

    always #5 clk = ~clk;

    handshake_constant_checker_if #(.DATA_WIDTH(DW)) ifa ();
    handshake_constant_checker_if #(.DATA_WIDTH(DW)) ifb ();

    assign ifa.ins        = ins_d;
    assign ifa.ins_valid  = valid_d;
    assign ifa.outs_ready = ordy_d;
    assign ifb.ins        = ins_d;
    assign ifb.ins_valid  = valid_d;
    assign ifb.outs_ready = ordy_d;

    logic [15:0] mc_a, mm_a;
    logic        err_a;
    logic [31:0] fb_a;
    logic [3:0]  mc_b, mm_b;
    logic        err_b;
    logic [31:0] fb_b;

    handshake_constant_checker #(
        .DATA_WIDTH(DW), .EXPECTED(EXP), .TOKEN_DEPTH(DEPTH), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(rst), .hs(ifa.slave),
        .match_count(mc_a), .mismatch_count(mm_a), .error(err_a), .first_bad(fb_a)
    );

    handshake_constant_checker #(
        .DATA_WIDTH(DW), .EXPECTED(EXP), .TOKEN_DEPTH(DEPTH), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .hs(ifb.slave),
        .match_count(mc_b), .mismatch_count(mm_b), .error(err_b), .first_bad(fb_b)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: plain token counts, saturation applied only when comparing.
    int          m_occ = 0;
    int          m_match = 0;
    int          m_mis = 0;
    bit          m_err = 1'b0;
    logic [31:0] m_fb = 32'd0;
    bit          acc_last = 1'b0;
    bit          started = 1'b0;

    function automatic longint sat(input int v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : longint'(v);
    endfunction

    function automatic logic [31:0] exp_fb();
`ifdef HANDSHAKE_CONSTANT_CHECKER_CAPTURE_EN
        return m_fb;
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step();
        bit rdy, acc, pop;
        if (rst) begin
            m_occ = 0; m_match = 0; m_mis = 0; m_err = 1'b0; m_fb = 32'd0;
            acc_last = 1'b0;
        end else begin
            rdy = (m_occ < DEPTH);
            acc = valid_d && rdy;
            pop = (m_occ > 0) && ordy_d;
            if (acc) begin
                if (ins_d == EXP) begin
                    m_match++;
                end else begin
                    if (!m_err) m_fb = ins_d;
                    m_err = 1'b1;
                    m_mis++;
                end
            end
            m_occ = m_occ + (acc ? 1 : 0) - (pop ? 1 : 0);
            acc_last = acc;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("ins_ready_a",  64'(ifa.ins_ready),  64'(m_occ < DEPTH));
            chk("outs_valid_a", 64'(ifa.outs_valid), 64'(m_occ > 0));
            chk("match_a",      64'(mc_a),  64'(sat(m_match, 16)));
            chk("mismatch_a",   64'(mm_a),  64'(sat(m_mis, 16)));
            chk("error_a",      64'(err_a), 64'(m_err));
            chk("first_bad_a",  64'(fb_a),  64'(exp_fb()));
            chk("ins_ready_b",  64'(ifb.ins_ready),  64'(m_occ < DEPTH));
            chk("outs_valid_b", 64'(ifb.outs_valid), 64'(m_occ > 0));
            chk("match_b",      64'(mc_b),  64'(sat(m_match, 4)));
            chk("mismatch_b",   64'(mm_b),  64'(sat(m_mis, 4)));
            chk("error_b",      64'(err_b), 64'(m_err));
            chk("first_bad_b",  64'(fb_b),  64'(exp_fb()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] toks [4];
    logic [31:0] fb_expect;

    initial begin
        toks[0] = 32'h2B868BA3; toks[1] = 32'h00000001;
        toks[2] = 32'h2B868BA3; toks[3] = 32'hFFFFFFFF;

        rst = 1'b1;
        tick();
        tick();
        started = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ins_ready", 64'(ifa.ins_ready), 64'd1);
        chk("rst_outs_valid", 64'(ifa.outs_valid), 64'd0);
        chk("rst_match", 64'(mc_a), 64'd0);
        chk("rst_mismatch", 64'(mm_a), 64'd0);
        chk("rst_error", 64'(err_a), 64'd0);
        chk("rst_first_bad", 64'(fb_a), 64'd0);

        // Five matching tokens with a free-running sink.
        ins_d = EXP; valid_d = 1'b1; ordy_d = 1'b1;
        repeat (5) tick();
        valid_d = 1'b0;
        @(negedge clk);
        chk("t1_match", 64'(mc_a), 64'd5);
        chk("t1_mismatch", 64'(mm_a), 64'd0);
        chk("t1_error", 64'(err_a), 64'd0);
        tick(); tick();

        // Backpressure: buffer fills after two accepts, one pop reopens it.
        ordy_d = 1'b0; valid_d = 1'b1; ins_d = EXP;
        tick(); tick();
        @(negedge clk);
        chk("t2_full_ready", 64'(ifa.ins_ready), 64'd0);
        chk("t2_full_valid", 64'(ifa.outs_valid), 64'd1);
        tick();
        valid_d = 1'b0; ordy_d = 1'b1;
        tick();
        @(negedge clk);
        chk("t2_pop_ready", 64'(ifa.ins_ready), 64'd1);
        chk("t2_pop_valid", 64'(ifa.outs_valid), 64'd1);
        chk("t2_match", 64'(mc_a), 64'd7);
        tick(); tick();

        // Mixed tokens: two matches, two mismatches, first bad is 1.
        ordy_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ins_d = toks[k]; valid_d = 1'b1;
            tick();
        end
        valid_d = 1'b0;
        tick();
`ifdef HANDSHAKE_CONSTANT_CHECKER_CAPTURE_EN
        fb_expect = 32'h00000001;
`else
        fb_expect = 32'h00000000;
`endif
        @(negedge clk);
        chk("t3_match", 64'(mc_a), 64'd9);
        chk("t3_mismatch", 64'(mm_a), 64'd2);
        chk("t3_error", 64'(err_a), 64'd1);
        chk("t3_first_bad", 64'(fb_a), 64'(fb_expect));
        tick();

        // Simultaneous accept and pop at occupancy 1 for ten cycles.
        ins_d = EXP; valid_d = 1'b1; ordy_d = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("t4_steady_valid", 64'(ifa.outs_valid), 64'd1);
        end
        chk("t4_match", 64'(mc_a), 64'd20);
        ordy_d = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_full_ready", 64'(ifa.ins_ready), 64'd0);
        chk("t4_sat_b", 64'(mc_b), 64'd15);

        // Reset with a full buffer, error set and a token offered.
        rst = 1'b1; valid_d = 1'b1; ordy_d = 1'b1;
        tick();
        rst = 1'b0; valid_d = 1'b0; ordy_d = 1'b0;
        @(negedge clk);
        chk("t5_outs_valid", 64'(ifa.outs_valid), 64'd0);
        chk("t5_ins_ready", 64'(ifa.ins_ready), 64'd1);
        chk("t5_match", 64'(mc_a), 64'd0);
        chk("t5_mismatch", 64'(mm_a), 64'd0);
        chk("t5_error", 64'(err_a), 64'd0);
        chk("t5_first_bad", 64'(fb_a), 64'd0);
        tick();

        // 17 matches saturate the 4-bit counter, then a single mismatch.
        ins_d = EXP; valid_d = 1'b1; ordy_d = 1'b1;
        repeat (17) tick();
        valid_d = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_match_b", 64'(mc_b), 64'd15);
        chk("t6_match_a", 64'(mc_a), 64'd17);
        ins_d = 32'hDEAD0001; valid_d = 1'b1;
        tick();
        valid_d = 1'b0;
        tick();
`ifdef HANDSHAKE_CONSTANT_CHECKER_CAPTURE_EN
        fb_expect = 32'hDEAD0001;
`else
        fb_expect = 32'h00000000;
`endif
        @(negedge clk);
        chk("t6_mismatch_b", 64'(mm_b), 64'd1);
        chk("t6_match_b_hold", 64'(mc_b), 64'd15);
        chk("t6_first_bad", 64'(fb_b), 64'(fb_expect));

        // Random traffic with upstream holding offered tokens until accepted.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!valid_d || acc_last) begin
                valid_d = ($urandom_range(0, 3) != 0);
                ins_d = ($urandom_range(0, 1) == 1) ? EXP : 32'($urandom);
            end
            ordy_d = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b0;
        valid_d = 1'b0;
        tick();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
